scoreboard_7seg_driver: RTL and testbench

Time-multiplexed driver for the 8-digit seven-segment scoreboard beside the LED matrix. Consumes the game controller's `num_countdown`, `red_win_count` and `green_win_count` outputs and produces one-hot digit select and segment patterns, one digit per scan step. When a player's win count changes, that player's digits flash for a programmable number of blink half-periods.

---
 rtl/scoreboard_7seg_driver.sv | 211 +++++++++++++++++++++
 tb/tb_scoreboard_7seg_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_7seg_driver.sv
// -----------------------------------------------------------------------------
// scoreboard_7seg_driver
//
// Time-multiplexed driver for the 8-digit seven-segment scoreboard. One digit
// is driven per scan step, advanced by rising edges of the slow scan_clk.
//
// Digit map (idx order):
//   0 countdown units, 2 red tens, 3 red units, 5 green tens, 6 green units.
//   Digits 1, 4 and 7 are always blank, but they are still scanned so that
//   every digit keeps a 1/8 duty cycle.
//
// Optional feature, macro SCOREBOARD_WIN_FLASH_EN:
//   When a player's win count changes, that player's two digits flash for
//   FLASH_TOGGLES blink half-periods, which are counted on blink_clk edges.
//   Without the macro, blink_clk is ignored and the score digits always show.
//
// Parameters:
//   FLASH_TOGGLES    blink half-periods per flash (0..15; even values end visible)
//   SEG_ACTIVE_LOW   1: segment lines are active-low
//   DIGIT_ACTIVE_LOW 1: digit-select lines are active-low
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   scan_clk         async slow clock; each rising edge advances one digit
//   blink_clk        async slow clock; each rising edge is one flash half-period
//   en               display enable
//   countdown_active 1 shows the countdown digit, 0 blanks it
//   num_countdown    countdown value (10..15 shows "-")
//   red_win_count    red win count, 0..15
//   green_win_count  green win count, 0..15
//   seg_out          {dp,g,f,e,d,c,b,a}, registered; dp is never lit
//   digit_sel        one-hot digit enable, registered; bit i selects digit i
// -----------------------------------------------------------------------------
module scoreboard_7seg_driver #(
  parameter int unsigned FLASH_TOGGLES    = 6,
  parameter bit          SEG_ACTIVE_LOW   = 1'b0,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_clk,
  input  logic       blink_clk,
  input  logic       en,
  input  logic       countdown_active,
  input  logic [3:0] num_countdown,
  input  logic [3:0] red_win_count,
  input  logic [3:0] green_win_count,
  output logic [7:0] seg_out,
  output logic [7:0] digit_sel
);

  localparam logic [3:0] FLASH_LOAD = 4'(FLASH_TOGGLES);

  // a..g patterns for 0..9
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Counts never exceed 15, so the units digit is v or v-10.
  function automatic logic [3:0] units(input logic [3:0] v);
    units = (v >= 4'd10) ? v - 4'd10 : v;
  endfunction

  // ---------------------------------------------------------------------------
  // scan_clk synchronizer; the edge pulse is registered, which gives the
  // scan_clk -> idx latency of three clk edges.
  // ---------------------------------------------------------------------------
  logic scan_r_q, scan_rr_q, scan_pulse_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source, making the chain a true shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_r_q     <= 1'b0;
      scan_rr_q    <= 1'b0;
      scan_pulse_q <= 1'b0;
    end else begin
      scan_r_q     <= scan_clk;
      scan_rr_q    <= scan_r_q;
      scan_pulse_q <= scan_r_q & ~scan_rr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan index: held at 0 while disabled, so re-enabling starts at digit 0.
  // ---------------------------------------------------------------------------
  logic [2:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (!en)               idx_d = 3'd0;
    else if (scan_pulse_q) idx_d = idx_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= 3'd0;
    else     idx_q <= idx_d;
  end

  // ---------------------------------------------------------------------------
  // Win-change flash
  // ---------------------------------------------------------------------------
  logic red_blank, green_blank;

`ifdef SCOREBOARD_WIN_FLASH_EN
  logic       blink_r_q, blink_rr_q, blink_pulse_q;
  logic [3:0] red_prev_q, green_prev_q;
  logic [3:0] red_flash_q, red_flash_d;
  logic [3:0] green_flash_q, green_flash_d;

  // A count change reloads the counter and wins over a same-cycle decrement.
  always_comb begin
    red_flash_d   = red_flash_q;
    green_flash_d = green_flash_q;
    if (red_prev_q != red_win_count)
      red_flash_d = FLASH_LOAD;
    else if (blink_pulse_q && (red_flash_q != 4'd0))
      red_flash_d = red_flash_q - 4'd1;
    if (green_prev_q != green_win_count)
      green_flash_d = FLASH_LOAD;
    else if (blink_pulse_q && (green_flash_q != 4'd0))
      green_flash_d = green_flash_q - 4'd1;
  end

  // Prev registers take the live counts in reset so no flash follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_r_q     <= 1'b0;
      blink_rr_q    <= 1'b0;
      blink_pulse_q <= 1'b0;
      red_prev_q    <= red_win_count;
      green_prev_q  <= green_win_count;
      red_flash_q   <= 4'd0;
      green_flash_q <= 4'd0;
    end else begin
      blink_r_q     <= blink_clk;
      blink_rr_q    <= blink_r_q;
      blink_pulse_q <= blink_r_q & ~blink_rr_q;
      red_prev_q    <= red_win_count;
      green_prev_q  <= green_win_count;
      red_flash_q   <= red_flash_d;
      green_flash_q <= green_flash_d;
    end
  end

  // Odd counter value = the blanked half-period.
  assign red_blank   = red_flash_q[0];
  assign green_blank = green_flash_q[0];
`else
  logic unused_flash;
  assign unused_flash = ^{blink_clk, FLASH_LOAD};
  assign red_blank    = 1'b0;
  assign green_blank  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Digit content and registered outputs, polarity applied at the register
  // ---------------------------------------------------------------------------
  logic [6:0] seg_raw;
  logic [7:0] dig_raw;
  logic [7:0] seg_d, digit_d;
  logic [7:0] seg_q, digit_q;

  // NOTE: every variable gets a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    seg_raw = 7'h00;
    dig_raw = 8'h00;
    if (en) begin
      dig_raw = 8'b1 << idx_q;
      case (idx_q)
        3'd0: if (countdown_active)
                seg_raw = (num_countdown >= 4'd10) ? 7'h40 : seg7(num_countdown);
        3'd2: if (!red_blank && (red_win_count >= 4'd10))     seg_raw = 7'h06;
        3'd3: if (!red_blank)   seg_raw = seg7(units(red_win_count));
        3'd5: if (!green_blank && (green_win_count >= 4'd10)) seg_raw = 7'h06;
        3'd6: if (!green_blank) seg_raw = seg7(units(green_win_count));
        default: seg_raw = 7'h00;
      endcase
    end
    seg_d   = {1'b0, seg_raw} ^ {8{SEG_ACTIVE_LOW}};
    digit_d = dig_raw ^ {8{DIGIT_ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= {8{SEG_ACTIVE_LOW}};
      digit_q <= {8{DIGIT_ACTIVE_LOW}};
    end else begin
      seg_q   <= seg_d;
      digit_q <= digit_d;
    end
  end

  assign seg_out   = seg_q;
  assign digit_sel = digit_q;

endmodule

// File: tb/tb_scoreboard_7seg_driver.sv
// -----------------------------------------------------------------------------
// Directed testbench for scoreboard_7seg_driver with default parameters
// (FLASH_TOGGLES=6, active-high segments, active-low digit selects).
// Expected values are hand-computed constants; flash expectations depend on
// whether SCOREBOARD_WIN_FLASH_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_scoreboard_7seg_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_clk = 1'b0;
  logic       blink_clk = 1'b0;
  logic       en = 1'b0;
  logic       countdown_active = 1'b0;
  logic [3:0] num_countdown = 4'd0;
  logic [3:0] red_win_count = 4'd0;
  logic [3:0] green_win_count = 4'd0;
  logic [7:0] seg_out;
  logic [7:0] digit_sel;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx  = 0;

`ifdef SCOREBOARD_WIN_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  // Segments for counts 7/3/12, in idx order 0..7
  logic [7:0] exp_seg [8] = '{8'h07, 8'h00, 8'h00, 8'h4F, 8'h00, 8'h06, 8'h5B, 8'h00};
  // Active-low one-hot selects, in idx order 0..7
  logic [7:0] exp_sel [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  scoreboard_7seg_driver dut (
    .clk              (clk),
    .rst              (rst),
    .scan_clk         (scan_clk),
    .blink_clk        (blink_clk),
    .en               (en),
    .countdown_active (countdown_active),
    .num_countdown    (num_countdown),
    .red_win_count    (red_win_count),
    .green_win_count  (green_win_count),
    .seg_out          (seg_out),
    .digit_sel        (digit_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then step 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One scan_clk pulse; returns once the outputs show the new digit.
  task automatic scan_pulse();
    scan_clk = 1'b1;
    tick(4);
    scan_clk = 1'b0;
    tick(3);
    exp_idx = (exp_idx + 1) % 8;
  endtask

  task automatic scan_n(input int n);
    for (int k = 0; k < n; k++) scan_pulse();
  endtask

  // One blink_clk pulse; returns once blanking reflects the new counter.
  task automatic blink_pulse();
    blink_clk = 1'b1;
    tick(4);
    blink_clk = 1'b0;
    tick(3);
  endtask

  initial begin
    logic [7:0] red3_blank, red4_blank, grn0_blank;
    red3_blank = FLASH ? 8'h00 : 8'h4F;
    red4_blank = FLASH ? 8'h00 : 8'h66;
    grn0_blank = FLASH ? 8'h00 : 8'h3F;

    // ---------------- reset ----------------
    num_countdown    = 4'd7;
    countdown_active = 1'b1;
    red_win_count    = 4'd3;
    green_win_count  = 4'd12;
    rst = 1'b1;
    tick(3);
    check("reset_digit_sel", digit_sel, 8'hFF);
    check("reset_seg_out",   seg_out,   8'h00);

    rst = 1'b0;
    en  = 1'b1;
    tick(1);
    check("en_first_sel", digit_sel, 8'hFE);
    check("en_first_seg", seg_out,   8'h07);

    // ---------------- scan latency: outputs move on the 4th edge ----------------
    scan_clk = 1'b1;
    tick(3);
    check("scan_lat_hold", digit_sel, 8'hFE);
    tick(1);
    check("scan_lat_step", digit_sel, 8'hFD);
    scan_clk = 1'b0;
    tick(3);
    exp_idx = 1;
    check("scan_seg_1", seg_out, exp_seg[1]);

    // ---------------- full scan, 15 more edges (16 total) ----------------
    for (int k = 0; k < 15; k++) begin
      scan_pulse();
      check($sformatf("scan_sel_%0d", exp_idx), digit_sel, exp_sel[exp_idx]);
      check($sformatf("scan_seg_%0d", exp_idx), seg_out,   exp_seg[exp_idx]);
    end

    // ---------------- countdown rules at digit 0 ----------------
    check("cd_at_digit0", digit_sel, 8'hFE);
    num_countdown = 4'hB;
    tick(1);
    check("cd_dash", seg_out, 8'h40);
    countdown_active = 1'b0;
    tick(1);
    check("cd_inactive_blank", seg_out, 8'h00);
    num_countdown    = 4'd7;
    countdown_active = 1'b1;
    tick(1);
    check("cd_restored", seg_out, 8'h07);

    // ---------------- en dropped at idx 5 ----------------
    scan_n(5);
    check("en_at_idx5", digit_sel, 8'hDF);
    en = 1'b0;
    tick(1);
    check("en_off_sel", digit_sel, 8'hFF);
    check("en_off_seg", seg_out,   8'h00);
    tick(4);
    check("en_off_hold", digit_sel, 8'hFF);
    en = 1'b1;
    tick(1);
    exp_idx = 0;
    check("en_back_sel", digit_sel, 8'hFE);
    check("en_back_seg", seg_out,   8'h07);

    // ---------------- red flash, 2 -> 3 ----------------
    scan_n(3);
    check("red_at_idx3", digit_sel, 8'hF7);
    red_win_count = 4'd2;
    tick(2);
    red_win_count = 4'd3;
    tick(2);
    check("red_cnt6_vis", seg_out, 8'h4F);
    blink_pulse();
    check("red_cnt5_seg", seg_out,   red3_blank);
    check("red_cnt5_sel", digit_sel, 8'hF7);
    scan_n(3);
    check("green_unaffected", seg_out, 8'h5B);
    scan_n(5);
    check("red_cnt5_again", seg_out, red3_blank);
    blink_pulse();
    check("red_cnt4", seg_out, 8'h4F);
    blink_pulse();
    check("red_cnt3", seg_out, red3_blank);
    blink_pulse();
    check("red_cnt2", seg_out, 8'h4F);
    blink_pulse();
    check("red_cnt1", seg_out, red3_blank);
    blink_pulse();
    check("red_cnt0", seg_out, 8'h4F);
    blink_pulse();
    blink_pulse();
    check("red_stays_vis", seg_out, 8'h4F);

    // ---------------- reset mid-flash cancels it ----------------
    red_win_count = 4'd4;
    tick(2);
    blink_pulse();
    check("red4_flash", seg_out, red4_blank);
    rst = 1'b1;
    tick(1);
    check("rst_mid_sel", digit_sel, 8'hFF);
    check("rst_mid_seg", seg_out,   8'h00);
    rst = 1'b0;
    exp_idx = 0;
    tick(1);
    check("rst_mid_digit0", digit_sel, 8'hFE);
    scan_n(3);
    check("rst_flash_gone", seg_out, 8'h66);

    // ---------------- green 15 -> 0 with a same-cycle blink pulse ----------------
    scan_n(3);
    check("green_at_idx6", digit_sel, 8'hBF);
    green_win_count = 4'd14;
    tick(2);
    green_win_count = 4'd15;
    tick(2);
    check("green15_vis", seg_out, 8'h6D);
    // pulse_q is high during the cycle that follows the second edge
    blink_clk = 1'b1;
    tick(2);
    green_win_count = 4'd0;
    tick(2);
    blink_clk = 1'b0;
    tick(3);
    check("green_reload_wins", seg_out, 8'h3F);
    blink_pulse();
    check("green_cnt5", seg_out, grn0_blank);
    scan_n(7);
    check("green_tens_blank", seg_out, 8'h00);
    scan_n(1);
    repeat (5) blink_pulse();
    check("green_done_vis", seg_out, 8'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
